// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg: conventions shared by the DLX data-memory load and store paths.
// Contents:
//   SZ_*        access-size encodings carried on ld_size / st_size.
//   ld_state_t  load-return FSM states.
//   LANE_*      byte-lane masks in big-endian numbering. Lane 0 is bits [31:24].
//               The store mask logic uses the same numbering, so the load and
//               store paths cannot disagree on byte order.
//   lane_mask()     lanes touched by an access. Returns 0 for illegal accesses.
//   access_fault()  misaligned or reserved-size access.
package dlx_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_RESP = 2'b10
  } ld_state_t;

  localparam logic [3:0] LANE_B0   = 4'b1000;
  localparam logic [3:0] LANE_B1   = 4'b0100;
  localparam logic [3:0] LANE_B2   = 4'b0010;
  localparam logic [3:0] LANE_B3   = 4'b0001;
  localparam logic [3:0] LANE_H0   = 4'b1100;
  localparam logic [3:0] LANE_H1   = 4'b0011;
  localparam logic [3:0] LANE_W    = 4'b1111;
  localparam logic [3:0] LANE_NONE = 4'b0000;

  // Lane set for an access of `size` at byte offset `off`.
  // LANE_NONE marks a misaligned or reserved-size access.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = LANE_B0 >> off;
      SZ_HALF: m = off[0] ? LANE_NONE : (off[1] ? LANE_H1 : LANE_H0);
      SZ_WORD: m = (off == 2'b00) ? LANE_W : LANE_NONE;
      SZ_RSVD: m = LANE_NONE;
      default: m = LANE_NONE;
    endcase
    return m;
  endfunction

  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
    return (lane_mask(size, off) == LANE_NONE);
  endfunction

endpackage

// File: rtl/mem_load_align_if.sv
// mem_load_align_if: bundles the core-side load handshake and the memory-side
// read channel of the load-return path.
// Modports:
//   slave   the load-return block. It takes the request and read data, and
//           drives the response and the read strobe.
//   master  the environment, meaning the core plus the data memory.
interface mem_load_align_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32
);
  logic            ld_req;
  logic [ADDR-1:0] ld_addr;
  logic [1:0]      ld_size;
  logic            ld_unsigned;
  logic            ld_busy;
  logic            ld_done;
  logic [DATA-1:0] ld_data;
  logic            ld_err;
  logic [ADDR-3:0] mem_addr;
  logic            mem_read;
  logic            mem_ack;
  logic [DATA-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_size, ld_unsigned, mem_ack, mem_rdata,
    output ld_busy, ld_done, ld_data, ld_err, mem_addr, mem_read
  );

  modport master (
    output ld_req, ld_addr, ld_size, ld_unsigned, mem_ack, mem_rdata,
    input  ld_busy, ld_done, ld_data, ld_err, mem_addr, mem_read
  );
endinterface

// File: rtl/mem_load_align_extract.sv
// load_extract: purely combinational. It picks the addressed byte or halfword
// out of a big-endian 32-bit word and zero- or sign-extends it. Word accesses
// pass straight through.
// Ports:
//   rdata    in  32  memory word
//   off      in  2   byte offset (addr[1:0])
//   size     in  2   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   zero_ext in  1   1 = zero-fill, 0 = sign-extend
//   result   out 32  extended value; 0 for illegal accesses
module load_extract
  import dlx_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection uses the shared big-endian lane masks, then extends the result.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = 32'h0000_0000;
    case (lane_mask(size, off))
      LANE_B0: byte_s = rdata[31:24];
      LANE_B1: byte_s = rdata[23:16];
      LANE_B2: byte_s = rdata[15:8];
      LANE_B3: byte_s = rdata[7:0];
      LANE_H0: half_s = rdata[31:16];
      LANE_H1: half_s = rdata[15:0];
      default: begin
        byte_s = 8'h00;
        half_s = 16'h0000;
      end
    endcase
    case (size)
      SZ_BYTE: result = {{24{~zero_ext & byte_s[7]}}, byte_s};
      SZ_HALF: result = {{16{~zero_ext & half_s[15]}}, half_s};
      SZ_WORD: result = (off == 2'b00) ? rdata : 32'h0000_0000;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_load_align.sv
// mem_load_align: load-return path of the DLX data-memory interface.
// It takes a load request, issues a word read, waits for mem_ack, extracts and
// extends the addressed data, and returns it with a one-cycle ld_done pulse.
// Misaligned, reserved-size and timed-out loads complete with ld_err=1 and
// ld_data=0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  ld_req/ld_addr/ld_size/ld_unsigned    request, in
//                ld_busy/ld_done/ld_data/ld_err        response, out
//                mem_addr/mem_read                     read channel, out
//                mem_ack/mem_rdata                     read channel, in
// Parameters: ADDR (byte address width), DATA (fixed 32), TIMEOUT (0 = none).
module mem_load_align
  import dlx_mem_pkg::*;
#(
  parameter int ADDR    = 32,
  parameter int DATA    = 32,
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst_n,
  mem_load_align_if.slave bus
);

  localparam int  CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit  TO_EN = (TIMEOUT != 0);
  // Counter value in the last READ cycle allowed before the timeout fires.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  ld_state_t       state_r;
  ld_state_t       next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [1:0]      off_r;
  logic [1:0]      size_r;
  logic            zext_r;
  logic [ADDR-3:0] mem_addr_r;
  logic            mem_read_r;
  logic            ld_busy_r;
  logic            ld_done_r;
  logic            ld_err_r;
  logic [DATA-1:0] ld_data_r;
  logic            err_s;
  logic [DATA-1:0] data_s;
  logic [31:0]     extract_s;

  load_extract u_extract (
    .rdata    (bus.mem_rdata),
    .off      (off_r),
    .size     (size_r),
    .zero_ext (zext_r),
    .result   (extract_s)
  );

  // Next-state and response selection.
  // On mem_ack the ack beats a timeout firing in the same cycle.
  always_comb begin
    next_s     = state_r;
    cnt_next_s = {CNT_W{1'b0}};
    err_s      = 1'b0;
    data_s     = ld_data_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ld_req) begin
          if (access_fault(bus.ld_size, bus.ld_addr[1:0])) begin
            next_s = ST_RESP;
            err_s  = 1'b1;
            data_s = {DATA{1'b0}};
          end else begin
            next_s = ST_READ;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.mem_ack) begin
          next_s = ST_RESP;
          data_s = extract_s;
        end else if (TO_EN && (cnt_r == TO_LAST)) begin
          next_s = ST_RESP;
          err_s  = 1'b1;
          data_s = {DATA{1'b0}};
        end else begin
          next_s     = ST_READ;
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, the timeout counter and the registered outputs.
  // The outputs are decoded from next_s so that they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      ld_busy_r  <= 1'b0;
      ld_done_r  <= 1'b0;
      ld_err_r   <= 1'b0;
      ld_data_r  <= {DATA{1'b0}};
      mem_read_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      cnt_r      <= cnt_next_s;
      ld_busy_r  <= (next_s != ST_IDLE);
      ld_done_r  <= (next_s == ST_RESP);
      mem_read_r <= (next_s == ST_READ);
      if (next_s == ST_RESP) begin
        ld_data_r <= data_s;
        ld_err_r  <= err_s;
      end else begin
        ld_err_r  <= 1'b0;
      end
    end
  end

  // Request capture. The core does not have to hold its inputs after the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r <= {(ADDR-2){1'b0}};
      off_r      <= 2'b00;
      size_r     <= SZ_BYTE;
      zext_r     <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.ld_req) begin
      mem_addr_r <= bus.ld_addr[ADDR-1:2];
      off_r      <= bus.ld_addr[1:0];
      size_r     <= bus.ld_size;
      zext_r     <= bus.ld_unsigned;
    end
  end

  assign bus.ld_busy  = ld_busy_r;
  assign bus.ld_done  = ld_done_r;
  assign bus.ld_err   = ld_err_r;
  assign bus.ld_data  = ld_data_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_read = mem_read_r;

endmodule

// File: tb/tb_mem_load_align.sv
// tb_mem_load_align: scoreboard bench for mem_load_align.
// The stimulus task works out each expected response from the load rules
// (arithmetic on byte counts and offsets) and pushes it into a queue. A
// negedge monitor pops one entry and compares it every time ld_done is seen.
module tb_mem_load_align;
  import dlx_mem_pkg::*;

  localparam int TB_TIMEOUT = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [32:0] exp_q[$];

  mem_load_align_if #(.ADDR(32), .DATA(32)) bus ();

  mem_load_align #(.ADDR(32), .DATA(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {err, data} from the load rules, computed with plain arithmetic.
  function automatic logic [32:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input bit uns, input logic [31:0] rdata,
                                           input bit acked);
    int nb;
    int off;
    longint unsigned v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    off = int'(addr[1:0]);
    if (nb == 0 || (off % nb) != 0 || !acked) return {1'b1, 32'h0000_0000};
    v = (64'(rdata) >> (8 * (4 - nb - off))) % (64'd1 << (8 * nb));
    if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * nb));
    return {1'b0, v[31:0]};
  endfunction

  // Monitor: every ld_done pops one expected response.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && bus.ld_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("ld_data", bus.ld_data, e[31:0]);
        chk("ld_err", 32'(bus.ld_err), 32'(e[32]));
      end
    end
  end

  // One complete load. ack_cyc is the READ cycle that carries mem_ack; 0 means no ack.
  // poke=1 pulses ld_req in the 2nd READ cycle, and that pulse has to be ignored.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input bit uns,
                         input logic [31:0] rdata, input int ack_cyc, input bit poke);
    logic [32:0] pre;
    bit last;
    pre = ref_load(addr, size, uns, rdata, 1'b1);
    exp_q.push_back(ref_load(addr, size, uns, rdata, ack_cyc != 0));
    bus.ld_req      = 1'b1;
    bus.ld_addr     = addr;
    bus.ld_size     = size;
    bus.ld_unsigned = uns;
    @(posedge clk); #1;
    bus.ld_req      = 1'b0;
    bus.ld_addr     = $urandom;
    bus.ld_size     = 2'($urandom);
    bus.ld_unsigned = 1'($urandom);
    if (pre[32]) begin
      chk("err_path_done", 32'(bus.ld_done), 32'd1);
      chk("err_path_no_read", 32'(bus.mem_read), 32'd0);
    end else begin
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
        chk("mem_read_high", 32'(bus.mem_read), 32'd1);
        chk("mem_addr", 32'(bus.mem_addr), 32'(addr[31:2]));
        if (poke && k == 2) bus.ld_req = 1'b1;
        if (k == ack_cyc) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
        last = (k == ack_cyc) || (k == TB_TIMEOUT);
        @(posedge clk); #1;
        bus.ld_req    = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (last) break;
      end
      chk("resp_done", 32'(bus.ld_done), 32'd1);
      chk("resp_read_low", 32'(bus.mem_read), 32'd0);
    end
    @(posedge clk); #1;
    chk("back_to_idle", 32'(bus.ld_busy), 32'd0);
  endtask

  // Watchdog so that a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.ld_req = 1'b0; bus.ld_addr = 32'h0; bus.ld_size = 2'b00; bus.ld_unsigned = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.ld_busy), 32'd0);
    chk("rst_done", 32'(bus.ld_done), 32'd0);
    chk("rst_err", 32'(bus.ld_err), 32'd0);
    chk("rst_read", 32'(bus.mem_read), 32'd0);
    chk("rst_data", bus.ld_data, 32'd0);
    chk("rst_maddr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte lanes, signed then unsigned.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++)
        do_load(32'(i), SZ_BYTE, u[0], 32'h80FF_7F01, 1, 1'b0);
    // Halfwords, including a misaligned one.
    do_load(32'h0000_0000, SZ_HALF, 1'b0, 32'h8001_FFFE, 2, 1'b0);
    do_load(32'h0000_0002, SZ_HALF, 1'b1, 32'h8001_FFFE, 1, 1'b0);
    do_load(32'h0000_0001, SZ_HALF, 1'b0, 32'h8001_FFFE, 1, 1'b0);
    // Word with an ack delay of 5 and a stray request during READ.
    do_load(32'h0000_0104, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 5, 1'b1);
    // Timeout with no ack, then an ack in the last allowed cycle.
    do_load(32'h0000_0208, SZ_WORD, 1'b0, 32'h1234_5678, 0, 1'b0);
    do_load(32'h0000_0208, SZ_WORD, 1'b0, 32'h1234_5678, TB_TIMEOUT, 1'b0);
    // Reserved size and a misaligned word.
    do_load(32'h0000_0010, SZ_RSVD, 1'b0, 32'h0, 1, 1'b0);
    do_load(32'h0000_0012, SZ_WORD, 1'b0, 32'h0, 1, 1'b0);

    // Reset in the 2nd READ cycle, followed by a late ack.
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0300; bus.ld_size = SZ_WORD;
    @(posedge clk); #1;
    bus.ld_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_read", 32'(bus.mem_read), 32'd0);
    chk("midrst_busy", 32'(bus.ld_busy), 32'd0);
    chk("midrst_done", 32'(bus.ld_done), 32'd0);
    chk("midrst_data", bus.ld_data, 32'd0);
    chk("midrst_maddr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_ack_idle", 32'(bus.ld_busy), 32'd0);
    do_load(32'h0000_0300, SZ_WORD, 1'b0, 32'hCAFE_F00D, 3, 1'b0);

    // Random loads, with stray acks in the idle gaps between them.
    for (int n = 0; n < 40; n++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) a[0] = 1'b0;
        if (sz == SZ_WORD) a[1:0] = 2'b00;
      end
      do_load(a, sz, 1'($urandom), $urandom, $urandom_range(0, TB_TIMEOUT), 1'($urandom));
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        bus.mem_ack = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
